// File: rtl/mpa_ctrl_pkg.sv
// Shared constants, FSM encoding and stub slot extraction for the MPA BRAM writer.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package mpa_ctrl_pkg;

  localparam int FRAME_W   = 256;
  localparam int STUB_W    = 21;
  localparam int ADDR_W    = 7;
  localparam int FIRST_MSB = 229;
  localparam int ID_LSB    = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2
  } state_t;

  // Slot k occupies frame bits [FIRST_MSB - k*STUB_W -: STUB_W]; slot 0 is the most significant.
  function automatic logic [STUB_W-1:0] stub_at(input logic [FRAME_W-1:0] frame, input int k);
    return frame[FIRST_MSB - k*STUB_W -: STUB_W];
  endfunction

endpackage

// File: rtl/mpa_wr_ptr.sv
// Per-chip BRAM write pointer with full flag and sticky overflow.
// Latency: pointer, full and overflow update on the edge that samples inc.
// Backpressure: none; an increment on a full pointer (no wrap) is refused and flagged.
module mpa_wr_ptr
  import mpa_ctrl_pkg::*;
#(
  parameter bit WRAP = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  // Pointer advance; the top slot stays addressed once written so full means "last address used".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      ptr      <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (inc) begin
      if (full && !WRAP) begin
        overflow <= 1'b1;
      end else if (ptr == PTR_MAX) begin
        if (WRAP) begin
          ptr <= '0;
        end else begin
          full <= 1'b1;
        end
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpa_bram_wr_ctrl.sv
// Walks the stub slots of one captured CIC frame and writes each stub into the BRAM of its chipID.
// Latency: accept at edge t -> slot k write visible after edge t+2+k; ready again after edge t+2+N_STUBS.
// Backpressure: frame_ready low while loading/scanning or clearing; a refused frame pulses frame_drop.
module mpa_bram_wr_ctrl
  import mpa_ctrl_pkg::*;
#(
  parameter int N_CHIPS = 8,
  parameter int N_STUBS = 10,
  parameter bit WRAP    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      frame_valid,
  input  logic [FRAME_W-1:0]        frame_data,
  output logic                      frame_ready,
  output logic                      frame_drop,
  output logic [N_CHIPS-1:0]        bram_we,
  output logic [N_CHIPS*ADDR_W-1:0] bram_addr,
  output logic [STUB_W-1:0]         bram_din,
  output logic [N_CHIPS-1:0]        overflow,
  output logic                      busy
);

  localparam int SLOT_W = $clog2(N_STUBS + 1);

  state_t                    state;
  logic [SLOT_W-1:0]         slot;
  logic [FRAME_W-1:0]        frame_q;
  logic                      scan_act;
  logic [STUB_W-1:0]         cur_stub;
  logic [2:0]                cid;
  logic                      stub_vld;
  logic [N_CHIPS-1:0]        hit;
  logic [N_CHIPS-1:0]        we_d;
  logic [N_CHIPS-1:0]        full;
  logic [N_CHIPS*ADDR_W-1:0] ptr_flat;

  assign frame_ready = (state == IDLE) && !clear;

  // Slot index N_STUBS is a drain cycle: no write, lets the last write retire before ready returns.
  assign scan_act = (state == SCAN) && (slot != SLOT_W'(N_STUBS));
  assign cur_stub = stub_at(frame_q, scan_act ? int'(slot) : 0);
  assign cid      = cur_stub[ID_LSB +: 3];
  assign stub_vld = scan_act && (cur_stub != '0);

  for (genvar i = 0; i < N_CHIPS; i++) begin : g_chip
    logic [ADDR_W-1:0] ptr_i;

    // chipIDs with no BRAM never match any i, so they are skipped here.
    assign hit[i]  = stub_vld && (cid == 3'(i));
    assign we_d[i] = hit[i] && (WRAP || !full[i]);
    assign ptr_flat[i*ADDR_W +: ADDR_W] = ptr_i;

    mpa_wr_ptr #(.WRAP(WRAP)) u_ptr (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .inc      (hit[i]),
      .ptr      (ptr_i),
      .full     (full[i]),
      .overflow (overflow[i])
    );
  end

  // Frame FSM: accept, one load cycle, then one slot per clock plus the drain cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      slot    <= '0;
      frame_q <= '0;
      busy    <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      slot  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_valid) begin
            frame_q <= frame_data;
            slot    <= '0;
            state   <= LOAD;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          state <= SCAN;
        end
        SCAN: begin
          if (slot == SLOT_W'(N_STUBS)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            slot <= slot + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Registered BRAM port; address is the pointer sampled before its increment, data holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_we    <= '0;
      bram_din   <= '0;
      bram_addr  <= '0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= frame_valid && !frame_ready;
      bram_addr  <= ptr_flat;
      if (clear) begin
        bram_we <= '0;
      end else begin
        bram_we <= we_d;
        if (|we_d) begin
          bram_din <= cur_stub;
        end
      end
    end
  end

endmodule
